// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: register file with two registered read ports and one write port.
// Reads see a write to the same address on the same edge (bypass). An optional
// hardwired zero register is available. A pending (scoreboard) bit per register
// tracks producers that are still in flight, so decode can flag reads of
// registers that have not been written back yet.
module regfile_2r1w_sb #(
  parameter int WORD_SIZE  = 16,
  parameter int REG_COUNT  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [WORD_SIZE-1:0]  WDATA,
  input  logic                  RE_A,
  input  logic [ADDR_WIDTH-1:0] RADDR_A,
  output logic [WORD_SIZE-1:0]  RDATA_A,
  output logic                  RVALID_A,
  output logic                  HAZARD_A,
  input  logic                  RE_B,
  input  logic [ADDR_WIDTH-1:0] RADDR_B,
  output logic [WORD_SIZE-1:0]  RDATA_B,
  output logic                  RVALID_B,
  output logic                  HAZARD_B,
  input  logic                  RESV,
  input  logic [ADDR_WIDTH-1:0] RESV_ADDR,
  output logic [REG_COUNT-1:0]  PENDING
);

  logic [WORD_SIZE-1:0] regQ [REG_COUNT];
  logic [REG_COUNT-1:0] pendingQ, pendingD;

  logic [WORD_SIZE-1:0] rdataAQ, rdataAD, rdataBQ, rdataBD;
  logic                 rvalidAQ, rvalidAD, rvalidBQ, rvalidBD;
  logic                 hazardAQ, hazardAD, hazardBQ, hazardBD;

  logic wrEn;
  logic resvEn;

  // Qualify write and reservation: with the zero register enabled, address 0 is inert
  always_comb begin
    wrEn   = WE;
    resvEn = RESV;
    if ((ZERO_REG != 0) && (WADDR == '0)) wrEn = 1'b0;
    if ((ZERO_REG != 0) && (RESV_ADDR == '0)) resvEn = 1'b0;
  end

  // Scoreboard next state: writeback clears, and a same-edge reservation re-sets it
  always_comb begin
    pendingD = pendingQ;
    if (wrEn) pendingD[WADDR] = 1'b0;
    if (resvEn) pendingD[RESV_ADDR] = 1'b1;
  end

  // Port A read value with bypass; hazard uses the pre-edge scoreboard
  always_comb begin
    rdataAD  = rdataAQ;
    rvalidAD = RE_A;
    hazardAD = 1'b0;
    if (RE_A) begin
      if ((ZERO_REG != 0) && (RADDR_A == '0)) begin
        rdataAD = '0;
      end else if (WE && (WADDR == RADDR_A)) begin
        rdataAD = WDATA;
      end else begin
        rdataAD = regQ[RADDR_A];
      end
      hazardAD = pendingQ[RADDR_A] & ~(WE && (WADDR == RADDR_A));
    end
  end

  // Port B read value with bypass; hazard uses the pre-edge scoreboard
  always_comb begin
    rdataBD  = rdataBQ;
    rvalidBD = RE_B;
    hazardBD = 1'b0;
    if (RE_B) begin
      if ((ZERO_REG != 0) && (RADDR_B == '0)) begin
        rdataBD = '0;
      end else if (WE && (WADDR == RADDR_B)) begin
        rdataBD = WDATA;
      end else begin
        rdataBD = regQ[RADDR_B];
      end
      hazardBD = pendingQ[RADDR_B] & ~(WE && (WADDR == RADDR_B));
    end
  end

  // Register array and scoreboard state, cleared by synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < REG_COUNT; i++) regQ[i] <= '0;
      pendingQ <= '0;
    end else begin
      if (wrEn) regQ[WADDR] <= WDATA;
      pendingQ <= pendingD;
    end
  end

  // Registered read-port outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdataAQ  <= '0;
      rvalidAQ <= 1'b0;
      hazardAQ <= 1'b0;
      rdataBQ  <= '0;
      rvalidBQ <= 1'b0;
      hazardBQ <= 1'b0;
    end else begin
      rdataAQ  <= rdataAD;
      rvalidAQ <= rvalidAD;
      hazardAQ <= hazardAD;
      rdataBQ  <= rdataBD;
      rvalidBQ <= rvalidBD;
      hazardBQ <= hazardBD;
    end
  end

  assign RDATA_A  = rdataAQ;
  assign RVALID_A = rvalidAQ;
  assign HAZARD_A = hazardAQ;
  assign RDATA_B  = rdataBQ;
  assign RVALID_B = rvalidBQ;
  assign HAZARD_B = hazardBQ;
  assign PENDING  = pendingQ;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb: drives a ZERO_REG=1 and a ZERO_REG=0 instance with the same
// stimulus and compares both against a behavioural register-file model.
module tb_regfile_2r1w_sb;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic [3:0]  WADDR;
  logic [15:0] WDATA;
  logic        RE_A;
  logic [3:0]  RADDR_A;
  logic        RE_B;
  logic [3:0]  RADDR_B;
  logic        RESV;
  logic [3:0]  RESV_ADDR;

  logic [15:0] rdataA [2];
  logic [15:0] rdataB [2];
  logic        rvalidA [2];
  logic        rvalidB [2];
  logic        hazardA [2];
  logic        hazardB [2];
  logic [15:0] pending [2];

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = zero-register instance, 1 = ordinary instance
  logic [15:0] mem [2][16];
  logic [15:0] pend [2];
  logic [15:0] expRdataA [2];
  logic [15:0] expRdataB [2];
  logic        expRvalidA [2];
  logic        expRvalidB [2];
  logic        expHazardA [2];
  logic        expHazardB [2];

  regfile_2r1w_sb #(.WORD_SIZE(16), .REG_COUNT(16), .ADDR_WIDTH(4), .ZERO_REG(1)) dutZero (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE_A(RE_A), .RADDR_A(RADDR_A), .RDATA_A(rdataA[0]), .RVALID_A(rvalidA[0]), .HAZARD_A(hazardA[0]),
    .RE_B(RE_B), .RADDR_B(RADDR_B), .RDATA_B(rdataB[0]), .RVALID_B(rvalidB[0]), .HAZARD_B(hazardB[0]),
    .RESV(RESV), .RESV_ADDR(RESV_ADDR), .PENDING(pending[0])
  );

  regfile_2r1w_sb #(.WORD_SIZE(16), .REG_COUNT(16), .ADDR_WIDTH(4), .ZERO_REG(0)) dutPlain (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE_A(RE_A), .RADDR_A(RADDR_A), .RDATA_A(rdataA[1]), .RVALID_A(rvalidA[1]), .HAZARD_A(hazardA[1]),
    .RE_B(RE_B), .RADDR_B(RADDR_B), .RDATA_B(rdataB[1]), .RVALID_B(rvalidB[1]), .HAZARD_B(hazardB[1]),
    .RESV(RESV), .RESV_ADDR(RESV_ADDR), .PENDING(pending[1])
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Model read value for one instance, as seen before the edge
  function automatic logic [15:0] modelRead(input int k, input logic [3:0] addr);
    if (k == 0 && addr == 4'd0) return 16'h0000;
    if (WE && WADDR == addr) return WDATA;
    return mem[k][addr];
  endfunction

  // Advance the model by one rising edge using the inputs currently applied
  task automatic modelEdge();
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        for (int r = 0; r < 16; r++) mem[k][r] = 16'h0000;
        pend[k]       = 16'h0000;
        expRdataA[k]  = 16'h0000;
        expRdataB[k]  = 16'h0000;
        expRvalidA[k] = 1'b0;
        expRvalidB[k] = 1'b0;
        expHazardA[k] = 1'b0;
        expHazardB[k] = 1'b0;
      end else begin
        expRvalidA[k] = RE_A;
        expRvalidB[k] = RE_B;
        expHazardA[k] = RE_A && pend[k][RADDR_A] && !(WE && WADDR == RADDR_A);
        expHazardB[k] = RE_B && pend[k][RADDR_B] && !(WE && WADDR == RADDR_B);
        if (RE_A) expRdataA[k] = modelRead(k, RADDR_A);
        if (RE_B) expRdataB[k] = modelRead(k, RADDR_B);
        if (WE && !(k == 0 && WADDR == 4'd0)) begin
          mem[k][WADDR] = WDATA;
          pend[k][WADDR] = 1'b0;
        end
        if (RESV && !(k == 0 && RESV_ADDR == 4'd0)) pend[k][RESV_ADDR] = 1'b1;
      end
    end
  endtask

  // Compare every output of both instances with the model
  task automatic checkAll(input string step);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s.inst%0d.RDATA_A", step, k), 32'(rdataA[k]), 32'(expRdataA[k]));
      checkOutput($sformatf("%s.inst%0d.RDATA_B", step, k), 32'(rdataB[k]), 32'(expRdataB[k]));
      checkOutput($sformatf("%s.inst%0d.RVALID_A", step, k), 32'(rvalidA[k]), 32'(expRvalidA[k]));
      checkOutput($sformatf("%s.inst%0d.RVALID_B", step, k), 32'(rvalidB[k]), 32'(expRvalidB[k]));
      checkOutput($sformatf("%s.inst%0d.HAZARD_A", step, k), 32'(hazardA[k]), 32'(expHazardA[k]));
      checkOutput($sformatf("%s.inst%0d.HAZARD_B", step, k), 32'(hazardB[k]), 32'(expHazardB[k]));
      checkOutput($sformatf("%s.inst%0d.PENDING", step, k), 32'(pending[k]), 32'(pend[k]));
    end
  endtask

  // Apply one cycle of inputs, clock it, then check one time unit after the edge
  task automatic applyStimulus(input string step, input logic rst, input logic we, input logic [3:0] waddr,
                               input logic [15:0] wdata, input logic reA, input logic [3:0] raddrA,
                               input logic reB, input logic [3:0] raddrB, input logic resv,
                               input logic [3:0] resvAddr);
    RST = rst; WE = we; WADDR = waddr; WDATA = wdata;
    RE_A = reA; RADDR_A = raddrA; RE_B = reB; RADDR_B = raddrB;
    RESV = resv; RESV_ADDR = resvAddr;
    @(posedge CLK);
    modelEdge();
    #1;
    checkAll(step);
  endtask

  initial begin
    $display("[TB] start");
    //                 step       rst we  wa    wdata     reA ra    reB rb    resv ra
    applyStimulus("rst0",    1, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    applyStimulus("pre3",    0, 1, 4'd3, 16'h1234, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    applyStimulus("rstOvr",  1, 1, 4'd5, 16'h7777, 1, 4'd3, 0, 4'd0, 1, 4'd5);
    checkOutput("rstOvr.RVALID_A", 32'(rvalidA[0]), 32'd0);
    checkOutput("rstOvr.PENDING", 32'(pending[0]), 32'd0);
    applyStimulus("rdRst",   0, 0, 4'd0, 16'h0000, 1, 4'd3, 1, 4'd5, 0, 4'd0);
    checkOutput("rdRst.r3", 32'(rdataA[0]), 32'h0000);
    checkOutput("rdRst.r5", 32'(rdataB[1]), 32'h0000);
    applyStimulus("wr7",     0, 1, 4'd7, 16'hBEEF, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    applyStimulus("rd7",     0, 0, 4'd0, 16'h0000, 1, 4'd7, 1, 4'd7, 0, 4'd0);
    checkOutput("rd7.RDATA_A", 32'(rdataA[0]), 32'hBEEF);
    checkOutput("rd7.RDATA_B", 32'(rdataB[0]), 32'hBEEF);
    applyStimulus("idle",    0, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    checkOutput("idle.hold", 32'(rdataA[1]), 32'hBEEF);
    applyStimulus("wr2",     0, 1, 4'd2, 16'h1111, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    applyStimulus("byp2",    0, 1, 4'd2, 16'h2222, 1, 4'd2, 0, 4'd0, 0, 4'd0);
    checkOutput("byp2.RDATA_A", 32'(rdataA[0]), 32'h2222);
    applyStimulus("rd2",     0, 0, 4'd0, 16'h0000, 0, 4'd0, 1, 4'd2, 0, 4'd0);
    checkOutput("rd2.RDATA_B", 32'(rdataB[0]), 32'h2222);
    applyStimulus("wr0",     0, 1, 4'd0, 16'hFFFF, 0, 4'd0, 0, 4'd0, 1, 4'd0);
    applyStimulus("rd0",     0, 0, 4'd0, 16'h0000, 1, 4'd0, 0, 4'd0, 0, 4'd0);
    checkOutput("rd0.zero", 32'(rdataA[0]), 32'h0000);
    checkOutput("rd0.plain", 32'(rdataA[1]), 32'hFFFF);
    applyStimulus("resv4",   0, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0, 1, 4'd4);
    checkOutput("resv4.PENDING", 32'(pending[0]), 32'h0010);
    applyStimulus("haz4",    0, 0, 4'd0, 16'h0000, 1, 4'd4, 0, 4'd0, 0, 4'd0);
    checkOutput("haz4.HAZARD_A", 32'(hazardA[0]), 32'd1);
    applyStimulus("wb4",     0, 1, 4'd4, 16'h00AA, 1, 4'd4, 0, 4'd0, 0, 4'd0);
    checkOutput("wb4.HAZARD_A", 32'(hazardA[0]), 32'd0);
    checkOutput("wb4.RDATA_A", 32'(rdataA[0]), 32'h00AA);
    checkOutput("wb4.PENDING", 32'(pending[0]), 32'h0000);
    applyStimulus("resv9",   0, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0, 1, 4'd9);
    applyStimulus("sim9",    0, 1, 4'd9, 16'h5555, 0, 4'd0, 0, 4'd0, 1, 4'd9);
    checkOutput("sim9.PENDING9", 32'(pending[0][9]), 32'd1);
    applyStimulus("rd9",     0, 0, 4'd0, 16'h0000, 0, 4'd0, 1, 4'd9, 0, 4'd0);
    checkOutput("rd9.RDATA_B", 32'(rdataB[0]), 32'h5555);
    checkOutput("rd9.HAZARD_B", 32'(hazardB[0]), 32'd1);

    // Randomised traffic with narrow address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      applyStimulus($sformatf("rnd%0d", n),
                    ($urandom_range(0, 39) == 0),
                    1'($urandom), 4'($urandom_range(0, 7)), 16'($urandom),
                    1'($urandom), 4'($urandom_range(0, 7)),
                    1'($urandom), 4'($urandom_range(0, 7)),
                    1'($urandom), 4'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
Parametrised general-purpose register file for the CPU datapath: two registered read ports and one write port, with same-cycle write-to-read bypass and an optional hardwired zero register. Adds a per-register pending (scoreboard) bit so decode can detect reads of registers whose producer has not yet written back. Sits between decode (reads, reservations) and writeback (writes).

Parameters:
WORD_SIZE, 16, data width in bits
REG_COUNT, 16, number of registers (power of two, 2..256)
ADDR_WIDTH, 4, log2(REG_COUNT)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and reservations; 0 = register 0 is ordinary

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous active-high reset
WE  input  1  write enable (writeback)
WADDR  input  ADDR_WIDTH  write address
WDATA  input  WORD_SIZE  write data
RE_A  input  1  read request, port A
RADDR_A  input  ADDR_WIDTH  read address, port A
RDATA_A  output  WORD_SIZE  registered read data, port A
RVALID_A  output  1  RDATA_A updated this cycle
HAZARD_A  output  1  register read on port A was pending
RE_B, RADDR_B, RDATA_B, RVALID_B, HAZARD_B  as port A, port B
RESV  input  1  reserve destination register (set pending bit)
RESV_ADDR  input  ADDR_WIDTH  register to reserve
PENDING  output  REG_COUNT  pending bit vector, bit i = register i

Behaviour:
- One clock (CLK); reset synchronous, active-high (RST). RST high at an edge overrides all other inputs that edge.
- Reset values: all registers 0, PENDING 0, RDATA_A/B 0, RVALID_A/B 0, HAZARD_A/B 0.
- Write: WE=1 at edge -> reg[WADDR] <= WDATA, and PENDING[WADDR] cleared. ZERO_REG=1 and WADDR=0 -> no effect.
- Reserve: RESV=1 at edge -> PENDING[RESV_ADDR] set. ZERO_REG=1 and RESV_ADDR=0 -> ignored.
- WE and RESV same edge, same address: data written, PENDING bit ends SET (new producer in flight). Different addresses: both apply.
- Write to a non-pending register is legal; PENDING stays 0.
- Read latency 1 cycle. RE_x=1 at edge N -> at N: RDATA_x <= value, RVALID_x <= 1, HAZARD_x <= pending status. RE_x=0 -> RVALID_x <= 0, HAZARD_x <= 0, RDATA_x holds previous value.
- Read value: ZERO_REG=1 and addr 0 -> 0. Else if WE=1 same edge and WADDR=RADDR_x -> WDATA (bypass). Else reg[RADDR_x].
- Hazard: HAZARD_x <= RE_x & PENDING[RADDR_x] & ~(WE & WADDR==RADDR_x). A same-edge write resolves the hazard; a same-edge RESV on that address does NOT raise it (uses pre-edge PENDING).
- Both ports may read the same address same cycle; identical results.
- PENDING output is the registered vector, directly from state.
- No tristate outputs; all outputs driven at all times.
- Addresses >= REG_COUNT impossible by construction (REG_COUNT = 2^ADDR_WIDTH).

Test Plan:
- Reset: preload r3=0x1234, assert RST one cycle with WE=1, WADDR=5, RESV=1 -> afterwards read r3 and r5 give 0x0000, PENDING=0, RVALID=0 during reset cycle.
- Write/read: WE r7=0xBEEF, next cycle RE_A r7, RE_B r7 -> one cycle later RDATA_A=RDATA_B=0xBEEF, RVALID_A=RVALID_B=1, HAZARD=0; RE low next cycle -> RVALID=0, RDATA holds 0xBEEF.
- Bypass: r2=0x1111, same edge WE r2=0x2222 and RE_A r2 -> RDATA_A=0x2222; RE_B r2 next cycle -> 0x2222.
- Zero reg (ZERO_REG=1): WE r0=0xFFFF, RESV r0 -> RE_A r0 gives 0x0000, PENDING[0]=0; ZERO_REG=0 instance gives 0xFFFF.
- Scoreboard: RESV r4 -> PENDING=0x0010; RE_A r4 -> HAZARD_A=1; WE r4=0x00AA with RE_A r4 same edge -> HAZARD_A=0, RDATA_A=0x00AA, PENDING=0.
- Simultaneous: r9 pending, WE r9=0x5555 and RESV r9 same edge -> PENDING[9]=1, reg r9=0x5555; next RE_B r9 -> RDATA_B=0x5555, HAZARD_B=1.
